// File: rtl/keypad_scanner_if.sv
// Matrix-side and result-side signals of the keypad scanner. The scanner is the master;
// the matrix model/debouncer side is the slave.
interface keypad_scanner_if #(
  parameter int ROWS = 2,
  parameter int COLS = 4
);
  logic [COLS-1:0] columns;
  logic [ROWS-1:0] rows;
  logic [4:0]      information;
  logic            frameDone;

  modport master (
    input  columns,
    output rows,
    output information,
    output frameDone
  );

  modport slave (
    output columns,
    input  rows,
    input  information,
    input  frameDone
  );
endinterface

// File: rtl/keypad_scanner.sv
// Scans a ROWS x COLS passive key matrix one row at a time and publishes a
// ghost-rejected {pressed, 0, index} word once per frame.
module keypad_scanner #(
  parameter int ROWS   = 2,
  parameter int COLS   = 4,
  parameter int SETTLE = 3
) (
  input  logic             newClock,
  input  logic             reset,
  keypad_scanner_if.master bus
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW = $clog2(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE} state_t;

  state_t          state, state_next;
  logic [COLS-1:0] csync1, csync2;
  logic [RW-1:0]   row_cnt, row_next;
  logic [SW-1:0]   settle_cnt, settle_next;
  logic [ROWS-1:0] rows_q, rows_next;
  logic [1:0]      hits, hits_next, frame_hits;
  logic [2:0]      first_idx, idx_next, frame_idx;
  logic [4:0]      info_q, info_next;
  logic            done_q, done_next;

  // Columns idle high, so the synchroniser resets to "no key" rather than a phantom press.
  always_ff @(posedge newClock or posedge reset) begin
    if (reset) begin
      csync1 <= '1;
      csync2 <= '1;
    end else begin
      csync1 <= bus.columns;
      csync2 <= csync1;
    end
  end

  always_ff @(posedge newClock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      row_cnt    <= '0;
      settle_cnt <= '0;
      rows_q     <= '1;
      hits       <= '0;
      first_idx  <= '0;
      info_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_next;
      row_cnt    <= row_next;
      settle_cnt <= settle_next;
      rows_q     <= rows_next;
      hits       <= hits_next;
      first_idx  <= idx_next;
      info_q     <= info_next;
      done_q     <= done_next;
    end
  end

  always_comb begin
    state_next  = state;
    row_next    = row_cnt;
    settle_next = settle_cnt;
    rows_next   = rows_q;
    hits_next   = hits;
    idx_next    = first_idx;
    info_next   = info_q;
    done_next   = 1'b0;
    frame_hits  = hits;
    frame_idx   = first_idx;

    case (state)
      S_IDLE: begin
        state_next  = S_SETTLE;
        row_next    = '0;
        settle_next = '0;
        rows_next   = ~(ROWS'(1));
      end

      S_SETTLE: begin
        if (settle_cnt == SW'(SETTLE - 1)) begin
          state_next = S_SAMPLE;
        end else begin
          settle_next = settle_cnt + 1'b1;
        end
      end

      S_SAMPLE: begin
        // Count saturates at 2: anything beyond one hit is already a ghost.
        for (int c = 0; c < COLS; c++) begin
          if (!csync2[c]) begin
            if (frame_hits == 2'd0) begin
              frame_idx = 3'(int'(row_cnt) * COLS + c);
            end
            if (frame_hits != 2'd2) begin
              frame_hits = frame_hits + 2'd1;
            end
          end
        end
        state_next  = S_SETTLE;
        settle_next = '0;
        if (row_cnt == RW'(ROWS - 1)) begin
          row_next  = '0;
          info_next = (frame_hits == 2'd1) ? {2'b10, frame_idx} : 5'b00000;
          done_next = 1'b1;
          hits_next = '0;
          idx_next  = '0;
        end else begin
          row_next  = row_cnt + 1'b1;
          hits_next = frame_hits;
          idx_next  = frame_idx;
        end
        rows_next = ~(ROWS'(1) << row_next);
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.rows        = rows_q;
  assign bus.information = info_q;
  assign bus.frameDone   = done_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with ROWS=2, COLS=4, SETTLE=3 and a
// behavioural key matrix pulling columns low through pressed keys.
module tb_keypad_scanner;

  logic       newClock;
  logic       reset;
  logic [7:0] keys;
  logic       glitch0;
  int         checks;
  int         errors;

  keypad_scanner_if #(.ROWS(2), .COLS(4)) bus ();

  keypad_scanner #(.ROWS(2), .COLS(4), .SETTLE(3)) dut (
    .newClock (newClock),
    .reset    (reset),
    .bus      (bus)
  );

  initial newClock = 1'b0;
  always #5 newClock = ~newClock;

  // Key (r,c) is bit r*4+c; it shorts column c low while row r is driven low.
  always_comb begin
    logic [3:0] col;
    col = 4'b1111;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !bus.rows[r]) col[c] = 1'b0;
      end
    end
    if (glitch0) col[0] = 1'b0;
    bus.columns = col;
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge newClock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    keys = 8'h01;
    glitch0 = 1'b0;
    do_reset();
    repeat (9) @(negedge newClock);
    checks++;
    if (bus.information !== 5'b10000 || bus.frameDone !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_preload: info=%b done=%b, expected info=10000 done=1", bus.information, bus.frameDone);
    end
    repeat (2) @(negedge newClock);
    checks++;
    if (bus.rows !== 2'b10) begin
      errors++;
      $display("[TB] FAIL reset_row0_driven: rows=%b expected 10", bus.rows);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.rows !== 2'b11 || bus.information !== 5'b00000 || bus.frameDone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_async: rows=%b info=%b done=%b, expected rows=11 info=00000 done=0", bus.rows, bus.information, bus.frameDone);
    end
    @(negedge newClock);
    reset = 1'b0;
    keys = 8'h00;
    #1;
    checks++;
    if (bus.rows !== 2'b11) begin
      errors++;
      $display("[TB] FAIL reset_idle: rows=%b expected 11", bus.rows);
    end
    @(negedge newClock);
    checks++;
    if (bus.rows !== 2'b10 || bus.frameDone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_first_row: rows=%b done=%b expected rows=10 done=0", bus.rows, bus.frameDone);
    end
  endtask

  task automatic test_no_keys();
    logic [1:0] exp_rows;
    logic       exp_done;
    keys = 8'h00;
    glitch0 = 1'b0;
    do_reset();
    for (int i = 1; i <= 25; i++) begin
      @(negedge newClock);
      exp_rows = (((i - 1) % 8) < 4) ? 2'b10 : 2'b01;
      exp_done = (i == 9 || i == 17 || i == 25);
      checks++;
      if (bus.rows !== exp_rows || bus.frameDone !== exp_done || bus.information !== 5'b00000) begin
        errors++;
        $display("[TB] FAIL no_keys cyc %0d: rows=%b done=%b info=%b expected rows=%b done=%b info=00000",
                 i, bus.rows, bus.frameDone, bus.information, exp_rows, exp_done);
      end
    end
  endtask

  task automatic test_single_key();
    logic [4:0] exp_info;
    logic       exp_done;
    keys = 8'h40;
    glitch0 = 1'b0;
    do_reset();
    for (int i = 1; i <= 25; i++) begin
      @(negedge newClock);
      exp_info = (i >= 9) ? 5'b10110 : 5'b00000;
      exp_done = (i == 9 || i == 17 || i == 25);
      checks++;
      if (bus.information !== exp_info || bus.frameDone !== exp_done) begin
        errors++;
        $display("[TB] FAIL single_key cyc %0d: info=%b done=%b expected info=%b done=%b",
                 i, bus.information, bus.frameDone, exp_info, exp_done);
      end
    end
  endtask

  task automatic test_release();
    logic [4:0] exp_info;
    keys = 8'h01;
    glitch0 = 1'b0;
    do_reset();
    for (int i = 1; i <= 25; i++) begin
      @(negedge newClock);
      exp_info = (i >= 9 && i < 25) ? 5'b10000 : 5'b00000;
      checks++;
      if (bus.information !== exp_info) begin
        errors++;
        $display("[TB] FAIL release cyc %0d: info=%b expected %b", i, bus.information, exp_info);
      end
      // Cycle 14 sits inside row 1's settle window of the second frame.
      if (i == 14) keys = 8'h00;
    end
  endtask

  task automatic test_ghost();
    logic [7:0] patterns [2];
    logic       exp_done;
    patterns[0] = 8'h82;
    patterns[1] = 8'h06;
    glitch0 = 1'b0;
    for (int p = 0; p < 2; p++) begin
      keys = patterns[p];
      do_reset();
      for (int i = 1; i <= 17; i++) begin
        @(negedge newClock);
        exp_done = (i == 9 || i == 17);
        checks++;
        if (bus.information !== 5'b00000 || bus.frameDone !== exp_done) begin
          errors++;
          $display("[TB] FAIL ghost keys=%b cyc %0d: info=%b done=%b expected info=00000 done=%b",
                   patterns[p], i, bus.information, bus.frameDone, exp_done);
        end
      end
    end
  endtask

  task automatic test_settle_glitch();
    keys = 8'h00;
    glitch0 = 1'b0;
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      @(negedge newClock);
      checks++;
      if (bus.information !== 5'b00000) begin
        errors++;
        $display("[TB] FAIL settle_glitch cyc %0d: info=%b expected 00000", i, bus.information);
      end
      // Low only in each row's first settle cycle, so it has left csync before SAMPLE.
      glitch0 = (((i - 1) % 4) == 0);
    end
    glitch0 = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    keys    = 8'h00;
    glitch0 = 1'b0;
    test_reset();
    test_no_keys();
    test_single_key();
    test_release();
    test_ghost();
    test_settle_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Drives the row lines of a passive button matrix, samples the column lines and decodes each full scan frame into the 5-bit key-information word.
- Word format: bit4 = a key is pressed, bit3 = reserved (always 0), bits2:0 = key index.
- The word feeds the team's key debouncer. It is held constant for a whole frame so the debouncer sees a stable value across its polling cycles.
- Multiple simultaneous presses (ghosting) are rejected as "no key".

Parameters:
ROWS, 2, number of matrix rows driven; 1..8.
COLS, 4, number of matrix columns sampled; ROWS*COLS must not exceed 8.
SETTLE, 3, cycles a row is held before its columns are sampled; must be at least 3 to cover the 2-flop input synchroniser.

Ports:
newClock  input  1  scan clock; all state on the rising edge.
reset  input  1  asynchronous, active-high reset.
columns  input  COLS  matrix column lines; active-low, pulled up externally; asynchronous to newClock.
rows  output  ROWS  row drives; active-low one-hot; undriven rows are 1.
information  output  5  {pressed, 1'b0, key index[2:0]}; registered.
frameDone  output  1  one-cycle pulse when information is updated.

Behaviour:
- Reset (async, active-high):
  - rows = all ones; information = 5'b00000; frameDone = 0.
  - State = IDLE; row counter = 0; frame accumulators cleared.
  - Synchroniser flops are set to all ones.
- Input path: columns pass through a 2-flop synchroniser (csync) before any use.
- FSM states: IDLE, SETTLE, SAMPLE.
  - IDLE -> SETTLE after 1 cycle. rows becomes ~(1<<0). Settle counter = 0.
  - SETTLE: hold rows for SETTLE cycles, then -> SAMPLE.
  - SAMPLE: 1 cycle. The fully synchronised csync is evaluated for the current row r.
    - For each col c with csync[c] == 0, a hit is recorded with index = r*COLS + c.
    - Hit count saturates at 2. The index of the first hit is stored.
  - SAMPLE, r < ROWS-1: r <= r+1; rows <= ~(1<<(r+1)); -> SETTLE.
  - SAMPLE, r == ROWS-1: frame end; r <= 0; rows <= ~1; -> SETTLE. No IDLE between frames.
- Frame end, registered at the edge leaving the final SAMPLE:
  - Exactly one hit: information = {1'b1, 1'b0, index[2:0]}.
  - Zero hits or two or more hits (including multiple hits in one row): information = 5'b00000.
  - frameDone = 1 for exactly that cycle. Accumulators are cleared for the next frame.
- information changes only at frame end. It is held for a full frame of ROWS*(SETTLE+1) cycles.
- Frame length: ROWS*(SETTLE+1) cycles. The first frame after reset is 1 cycle longer (IDLE).
- Index arithmetic: 3-bit result. Unused upper index bits are 0 when ROWS*COLS < 8.
- Changes in columns during SETTLE are ignored. Only the SAMPLE-cycle value counts.
- A key released or pressed mid-frame is reflected only in rows not yet sampled. The word updates at the next frame end.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is discarded and no frameDone is issued.

Test Plan:
(Bench: ROWS=2, COLS=4, SETTLE=3. Frame = 8 cycles. Key model: column c is pulled low while rows[r] == 0 and key (r,c) is held.)
1. Assert reset mid-scan with row 0 driven -> rows=2'b11, information=5'b00000 and frameDone=0 immediately, without waiting for an edge. After release: one IDLE cycle, then rows=2'b10.
2. No keys, columns=4'b1111 -> information stays 5'b00000. frameDone pulses every 8 cycles; the first pulse comes 9 cycles after reset release.
3. Hold key (1,2) -> after the first full frame, information=5'b10110 (index 6), held for 8 cycles per frame. frameDone is coincident with the update.
4. Hold key (0,0) -> information=5'b10000. Release it midway through row 1 settle -> information remains 5'b10000 until that frame end, then 5'b00000.
5. Hold keys (0,1) and (1,3) together -> information=5'b00000 every frame (ghost rejection). Hold (0,1) and (0,2), same row -> 5'b00000.
6. Toggle column 0 during SETTLE cycles only, leaving it high in SAMPLE -> information=5'b00000; no spurious hit.
